// File: rtl/fb_pkg.sv
// fb_pkg: framebuffer geometry, fill-engine state encoding and colour names.
// Shared with the display controller.
package fb_pkg;

  localparam int unsigned FB_W    = 320;
  localparam int unsigned FB_H    = 240;
  localparam int unsigned ADDR_W  = 17;
  localparam int unsigned COLOR_W = 3;

  // Fill-engine states, kept as plain constants for legacy tools.
  typedef logic [1:0] fb_state_t;
  localparam fb_state_t ST_IDLE  = 2'd0;
  localparam fb_state_t ST_SETUP = 2'd1;
  localparam fb_state_t ST_RUN   = 2'd2;
  localparam fb_state_t ST_DONE  = 2'd3;

  // RGB 1:1:1 colours.
  typedef enum logic [COLOR_W-1:0] {
    BLACK   = 3'b000,
    BLUE    = 3'b001,
    GREEN   = 3'b010,
    CYAN    = 3'b011,
    RED     = 3'b100,
    MAGENTA = 3'b101,
    YELLOW  = 3'b110,
    WHITE   = 3'b111
  } fb_color_e;

endpackage

// File: rtl/fb_fill_engine_if.sv
// fb_fill_engine_if: command handshake, status and framebuffer write port of the fill engine.
// FB_FILL_PIXCNT_EN adds the pix_count status signal.
interface fb_fill_engine_if;
  import fb_pkg::*;

  logic               cmd_valid;
  logic               cmd_ready;
  logic [8:0]         cmd_x;
  logic [7:0]         cmd_y;
  logic [8:0]         cmd_w;
  logic [7:0]         cmd_h;
  logic [COLOR_W-1:0] cmd_color;
  logic               busy;
  logic               done;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [COLOR_W-1:0] wr_data;
`ifdef FB_FILL_PIXCNT_EN
  logic [ADDR_W-1:0]  pix_count;
`endif

  // Engine side: consumes commands, drives the framebuffer write port.
  modport master (
    input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
    output cmd_ready, busy, done, wr_en, wr_addr, wr_data
`ifdef FB_FILL_PIXCNT_EN
    , output pix_count
`endif
  );

  // Glue side: issues commands, observes status and writes.
  modport slave (
    output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
    input  cmd_ready, busy, done, wr_en, wr_addr, wr_data
`ifdef FB_FILL_PIXCNT_EN
    , input pix_count
`endif
  );

endinterface

// File: rtl/fb_rect_clip.sv
// fb_rect_clip: clips a fill rectangle to the framebuffer and forms its start address.
module fb_rect_clip
  import fb_pkg::*;
(
  input  logic [8:0]        x,
  input  logic [7:0]        y,
  input  logic [8:0]        w,
  input  logic [7:0]        h,
  output logic [8:0]        w_eff,
  output logic [7:0]        h_eff,
  output logic [ADDR_W-1:0] start_addr,
  output logic              empty
);

  logic       x_out;
  logic       y_out;
  logic [8:0] rem_w;
  logic [7:0] rem_h;

  // Clip to the right/bottom edges; y*320 is built as y*256 + y*64 to avoid a multiplier.
  always_comb begin
    x_out      = (x >= 9'(FB_W));
    y_out      = (y >= 8'(FB_H));
    rem_w      = 9'(FB_W) - x;
    rem_h      = 8'(FB_H) - y;
    w_eff      = (w < rem_w) ? w : rem_w;
    h_eff      = (h < rem_h) ? h : rem_h;
    empty      = x_out | y_out | (w == 9'd0) | (h == 8'd0);
    start_addr = {1'b0, y, 8'b0} + {3'b0, y, 6'b0} + {8'b0, x};
  end

endmodule

// File: rtl/fb_fill_engine.sv
// fb_fill_engine: rectangle fill master for the 320x240x3bpp framebuffer write port.
// One pixel write per clock. Optional FB_FILL_PIXCNT_EN adds pix_count, the number of
// pixels written by the last completed command.
module fb_fill_engine
  import fb_pkg::*;
(
  input logic              clock,
  input logic              reset_n,
  fb_fill_engine_if.master bus
);

  fb_state_t          state_q, state_d;
  logic [8:0]         x_q, x_d, w_q, w_d;
  logic [7:0]         y_q, y_d, h_q, h_d;
  logic [COLOR_W-1:0] color_q, color_d;
  logic [8:0]         col_q, col_d;
  logic [7:0]         row_q, row_d;
  logic [ADDR_W-1:0]  row_base_q, row_base_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [COLOR_W-1:0] wr_data_q, wr_data_d;
`ifdef FB_FILL_PIXCNT_EN
  logic [ADDR_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic [ADDR_W-1:0]  pix_count_q, pix_count_d;
`endif

  logic [8:0]         w_eff;
  logic [7:0]         h_eff;
  logic [ADDR_W-1:0]  start_addr;
  logic               clip_empty;
  logic               last_col;
  logic               last_row;

  // Latched command fields stay stable for the whole command, so the clip outputs do too.
  fb_rect_clip u_clip (
    .x          (x_q),
    .y          (y_q),
    .w          (w_q),
    .h          (h_q),
    .w_eff      (w_eff),
    .h_eff      (h_eff),
    .start_addr (start_addr),
    .empty      (clip_empty)
  );

  assign last_col = (col_q == w_eff - 9'd1);
  assign last_row = (row_q == h_eff - 8'd1);

  // Next-state: latch command, load start address, walk columns then rows.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    w_d        = w_q;
    h_d        = h_q;
    color_d    = color_q;
    col_d      = col_q;
    row_d      = row_q;
    row_base_d = row_base_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
`ifdef FB_FILL_PIXCNT_EN
    pix_cnt_d   = pix_cnt_q;
    pix_count_d = pix_count_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          x_d     = bus.cmd_x;
          y_d     = bus.cmd_y;
          w_d     = bus.cmd_w;
          h_d     = bus.cmd_h;
          color_d = bus.cmd_color;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        col_d = 9'd0;
        row_d = 8'd0;
`ifdef FB_FILL_PIXCNT_EN
        pix_cnt_d = '0;
`endif
        if (clip_empty) begin
          state_d = ST_DONE;
`ifdef FB_FILL_PIXCNT_EN
          pix_count_d = '0;
`endif
        end else begin
          // Write port registers are loaded here so they hold until the first write.
          state_d    = ST_RUN;
          row_base_d = start_addr;
          wr_addr_d  = start_addr;
          wr_data_d  = color_q;
        end
      end
      ST_RUN: begin
`ifdef FB_FILL_PIXCNT_EN
        pix_cnt_d = pix_cnt_q + 17'd1;
`endif
        if (!last_col) begin
          col_d     = col_q + 9'd1;
          wr_addr_d = wr_addr_q + 17'd1;
        end else if (!last_row) begin
          col_d      = 9'd0;
          row_d      = row_q + 8'd1;
          row_base_d = row_base_q + ADDR_W'(FB_W);
          wr_addr_d  = row_base_q + ADDR_W'(FB_W);
        end else begin
          // Last pixel: address is left on it so wr_addr holds afterwards.
          state_d = ST_DONE;
`ifdef FB_FILL_PIXCNT_EN
          pix_count_d = pix_cnt_q + 17'd1;
`endif
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any command immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      w_q        <= '0;
      h_q        <= '0;
      color_q    <= '0;
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
`ifdef FB_FILL_PIXCNT_EN
      pix_cnt_q   <= '0;
      pix_count_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      w_q        <= w_d;
      h_q        <= h_d;
      color_q    <= color_d;
      col_q      <= col_d;
      row_q      <= row_d;
      row_base_q <= row_base_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
`ifdef FB_FILL_PIXCNT_EN
      pix_cnt_q   <= pix_cnt_d;
      pix_count_q <= pix_count_d;
`endif
    end
  end

  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.busy      = (state_q == ST_SETUP) || (state_q == ST_RUN);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.wr_en     = (state_q == ST_RUN);
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
`ifdef FB_FILL_PIXCNT_EN
  assign bus.pix_count = pix_count_q;
`endif

endmodule

// File: tb/tb_fb_fill_engine.sv
// tb_fb_fill_engine: directed bench for fb_fill_engine. Outputs are sampled on the falling
// edge; commands are driven on the falling edge and accepted on the following rising edge.
// Also checks pix_count when built with FB_FILL_PIXCNT_EN.
module tb_fb_fill_engine;
  import fb_pkg::*;

  logic clock;
  logic reset_n;
  int   n_checks;
  int   n_bad;
  int   last_addr;
  int   last_data;

  fb_fill_engine_if bus_if ();

  fb_fill_engine dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive_cmd(input int x, input int y, input int w, input int h, input int color);
    bus_if.cmd_x     = 9'(x);
    bus_if.cmd_y     = 8'(y);
    bus_if.cmd_w     = 9'(w);
    bus_if.cmd_h     = 8'(h);
    bus_if.cmd_color = 3'(color);
    bus_if.cmd_valid = 1'b1;
  endtask

  // Issue one command and check every cycle up to two idle cycles after done.
  // ew/eh/start are the hand-computed clipped width, height and start address.
  task automatic do_cmd(input string tag, input int x, input int y, input int w, input int h,
                        input int color, input int ew, input int eh, input int start,
                        input bit hold_valid);
    int n;
    int a;
    n = ew * eh;
    @(negedge clock);
    check_eq({tag, " ready"}, 32'(bus_if.cmd_ready), 1);
    drive_cmd(x, y, w, h, color);
    @(negedge clock);
    if (!hold_valid) bus_if.cmd_valid = 1'b0;
    check_eq({tag, " setup busy"}, 32'(bus_if.busy), 1);
    check_eq({tag, " setup ready"}, 32'(bus_if.cmd_ready), 0);
    check_eq({tag, " setup wr_en"}, 32'(bus_if.wr_en), 0);
    check_eq({tag, " setup addr hold"}, 32'(bus_if.wr_addr), 32'(last_addr));
    check_eq({tag, " setup data hold"}, 32'(bus_if.wr_data), 32'(last_data));
    for (int r = 0; r < eh; r++) begin
      for (int c = 0; c < ew; c++) begin
        @(negedge clock);
        a = start + r * int'(FB_W) + c;
        check_eq({tag, " wr_en"}, 32'(bus_if.wr_en), 1);
        check_eq({tag, " wr_addr"}, 32'(bus_if.wr_addr), 32'(a));
        check_eq({tag, " wr_data"}, 32'(bus_if.wr_data), 32'(color));
        check_eq({tag, " run done"}, 32'(bus_if.done), 0);
        last_addr = a;
        last_data = color;
      end
    end
    @(negedge clock);
    bus_if.cmd_valid = 1'b0;
    check_eq({tag, " done"}, 32'(bus_if.done), 1);
    check_eq({tag, " done busy"}, 32'(bus_if.busy), 0);
    check_eq({tag, " done wr_en"}, 32'(bus_if.wr_en), 0);
    check_eq({tag, " done ready"}, 32'(bus_if.cmd_ready), 0);
    check_eq({tag, " done addr hold"}, 32'(bus_if.wr_addr), 32'(last_addr));
`ifdef FB_FILL_PIXCNT_EN
    check_eq({tag, " pix_count"}, 32'(bus_if.pix_count), 32'(n));
`endif
    repeat (2) begin
      @(negedge clock);
      check_eq({tag, " idle done"}, 32'(bus_if.done), 0);
      check_eq({tag, " idle ready"}, 32'(bus_if.cmd_ready), 1);
      check_eq({tag, " idle busy"}, 32'(bus_if.busy), 0);
      check_eq({tag, " idle wr_en"}, 32'(bus_if.wr_en), 0);
      check_eq({tag, " idle data hold"}, 32'(bus_if.wr_data), 32'(last_data));
`ifdef FB_FILL_PIXCNT_EN
      check_eq({tag, " pix_count hold"}, 32'(bus_if.pix_count), 32'(n));
`endif
    end
  endtask

  initial begin
    n_checks         = 0;
    n_bad            = 0;
    last_addr        = 0;
    last_data        = 0;
    reset_n          = 1'b0;
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_x     = '0;
    bus_if.cmd_y     = '0;
    bus_if.cmd_w     = '0;
    bus_if.cmd_h     = '0;
    bus_if.cmd_color = '0;

    repeat (3) @(negedge clock);
    check_eq("rst ready", 32'(bus_if.cmd_ready), 1);
    check_eq("rst busy", 32'(bus_if.busy), 0);
    check_eq("rst done", 32'(bus_if.done), 0);
    check_eq("rst wr_en", 32'(bus_if.wr_en), 0);
    check_eq("rst wr_addr", 32'(bus_if.wr_addr), 0);
    check_eq("rst wr_data", 32'(bus_if.wr_data), 0);
`ifdef FB_FILL_PIXCNT_EN
    check_eq("rst pix_count", 32'(bus_if.pix_count), 0);
`endif
    reset_n = 1'b1;

    do_cmd("single", 0, 0, 1, 1, 5, 1, 1, 0, 1'b0);
    do_cmd("rect3x2", 10, 20, 3, 2, 2, 3, 2, 6410, 1'b0);
    do_cmd("clip_corner", 318, 239, 5, 5, 3, 2, 1, 76798, 1'b0);
    do_cmd("clip_right", 319, 0, 9, 2, 4, 1, 2, 319, 1'b0);
    do_cmd("empty_w0", 4, 4, 0, 3, 1, 0, 0, 0, 1'b0);
    do_cmd("empty_x320", 320, 0, 4, 4, 1, 0, 0, 0, 1'b0);
    do_cmd("empty_y240", 0, 240, 1, 1, 6, 0, 0, 0, 1'b0);
    do_cmd("full", 0, 0, 320, 240, 7, 320, 240, 0, 1'b1);

    // Abort mid-run: reset must drop wr_en at once and suppress done.
    @(negedge clock);
    drive_cmd(10, 20, 3, 2, 4);
    @(negedge clock);
    bus_if.cmd_valid = 1'b0;
    @(negedge clock);
    check_eq("abort wr1 addr", 32'(bus_if.wr_addr), 6410);
    @(negedge clock);
    check_eq("abort wr2 addr", 32'(bus_if.wr_addr), 6411);
    check_eq("abort wr2 en", 32'(bus_if.wr_en), 1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("abort wr_en", 32'(bus_if.wr_en), 0);
    check_eq("abort busy", 32'(bus_if.busy), 0);
    check_eq("abort done", 32'(bus_if.done), 0);
    check_eq("abort ready", 32'(bus_if.cmd_ready), 1);
    check_eq("abort wr_addr", 32'(bus_if.wr_addr), 0);
    @(negedge clock);
    reset_n   = 1'b1;
    last_addr = 0;
    last_data = 0;
    repeat (4) begin
      @(negedge clock);
      check_eq("post-abort done", 32'(bus_if.done), 0);
      check_eq("post-abort wr_en", 32'(bus_if.wr_en), 0);
    end
    do_cmd("after_abort", 5, 1, 2, 2, 6, 2, 2, 325, 1'b0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
